cameralink_timing_gen: RTL and testbench

- Sequencer and test-pattern source for the 36-bit Medium Camera Link transmit path.
- Generates frame, line and data-valid timing (Fval/Lval/Dval) plus 12-bit R/G/B pixel words, all synchronous to the pixel clock.
- Outputs connect directly to the pixel inputs of the Medium packing/routing stage.
- Start, stop and pattern control come from host registers; changes take effect only on frame boundaries.

---
 rtl/cameralink_pkg.sv | 28 ++
 rtl/cameralink_pattern_gen.sv | 21 ++
 rtl/cameralink_timing_gen.sv | 182 ++++++++++++++++++
 tb/tb_cameralink_timing_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cameralink_pkg.sv
// cameralink_pkg: shared state encoding, pattern codes and colour-bar table for the Camera Link timing generator
package cameralink_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FV_PRE,
    ST_LINE,
    ST_HBLANK,
    ST_FV_POST,
    ST_VBLANK
  } state_t;
  typedef enum logic [1:0] {
    PAT_HRAMP,
    PAT_VRAMP,
    PAT_BARS,
    PAT_FCNT
  } pattern_t;
  // {R,G,B} per bar; index 0 is the leftmost bar (white), index 7 the rightmost (black)
  localparam logic [7:0][35:0] BAR_RGB = {
    36'h000_000_000,
    36'h000_000_fff,
    36'hfff_000_000,
    36'hfff_000_fff,
    36'h000_fff_000,
    36'h000_fff_fff,
    36'hfff_fff_000,
    36'hfff_fff_fff
  };
endpackage

// File: rtl/cameralink_pattern_gen.sv
// cameralink_pattern_gen: combinational test-pattern source
//   x, y     : 12-bit pixel coordinates of the pixel being produced
//   fcnt     : low 12 bits of the completed-frame counter
//   pattern  : pattern latched at the frame boundary
//   bar      : colour-bar index of pixel x
//   rgb      : {R,G,B} 12 bits each, registered by the parent
module cameralink_pattern_gen
  import cameralink_pkg::*;
(
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [11:0] fcnt,
  input  pattern_t    pattern,
  input  logic [2:0]  bar,
  output logic [35:0] rgb
);
  always_comb
    rgb = pattern == PAT_HRAMP ? {3{x}} :
          pattern == PAT_VRAMP ? {3{y}} :
          pattern == PAT_BARS  ? BAR_RGB[bar] : {3{fcnt}};
endmodule

// File: rtl/cameralink_timing_gen.sv
// cameralink_timing_gen: Fval/Lval/Dval sequencer and test-pattern source for the Medium Camera Link transmit path
//   I_Pixel_clk, I_Rst_n   : pixel clock, asynchronous active-low reset
//   I_Start                : starts a frame sequence when sampled in IDLE
//   I_Stop                 : requests a stop at the end of the current frame
//   I_Continuous           : 1 = free-run frames, 0 = one frame per start
//   I_Pattern              : 0 H ramp, 1 V ramp, 2 colour bars, 3 frame-count flat
//   O_Pixel_R/G/B          : 12-bit pixel data, zero whenever Lval is low
//   O_Pixel_Fval/Lval/Dval : timing
//   O_Busy, O_Frame_Done, O_Frame_Cnt : status
module cameralink_timing_gen
  import cameralink_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_BLANK  = 280,
  parameter int V_ACTIVE = 1080,
  parameter int V_BLANK  = 45,
  parameter int FV_GAP   = 4,
  parameter int CNT_W    = 16
) (
  input  logic        I_Pixel_clk,
  input  logic        I_Rst_n,
  input  logic        I_Start,
  input  logic        I_Stop,
  input  logic        I_Continuous,
  input  logic [1:0]  I_Pattern,
  output logic [11:0] O_Pixel_R,
  output logic [11:0] O_Pixel_G,
  output logic [11:0] O_Pixel_B,
  output logic        O_Pixel_Fval,
  output logic        O_Pixel_Lval,
  output logic        O_Pixel_Dval,
  output logic        O_Busy,
  output logic        O_Frame_Done,
  output logic [15:0] O_Frame_Cnt
);
  localparam int VB_CYC = V_BLANK == 0 ? 1 : V_BLANK * (H_ACTIVE + H_BLANK);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(FV_GAP - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
  localparam logic [2*CNT_W-1:0] VB_LAST = (2*CNT_W)'(VB_CYC - 1);
  state_t             state;
  pattern_t           pat;
  logic [CNT_W-1:0]   hcnt;
  logic [CNT_W-1:0]   ycnt;
  logic [CNT_W-1:0]   bar_cnt;
  logic [2*CNT_W-1:0] vcnt;
  logic [2:0]         bar;
  logic [35:0]        pix;
  logic [35:0]        rgb;
  logic               fval;
  logic               lval;
  logic               busy;
  logic               frame_done;
  logic               stop;
  logic [15:0]        frame_cnt;
  logic [11:0]        px;
  logic [11:0]        py;
  logic [2:0]         pbar;
  logic [CNT_W-1:0]   pbar_cnt;
  // Coordinates of the pixel that will be on the outputs after the next edge,
  // so pattern data lands in the same register stage as Lval.
  always_comb begin
    px = state == ST_LINE ? hcnt[11:0] + 12'd1 : 12'd0;
    py = state == ST_HBLANK ? ycnt[11:0] + 12'd1 : state == ST_LINE ? ycnt[11:0] : 12'd0;
    pbar_cnt = state == ST_LINE && bar_cnt != BAR_LAST ? bar_cnt + 1'b1 : '0;
    pbar = state != ST_LINE ? 3'd0 : bar_cnt == BAR_LAST ? bar + 3'd1 : bar;
  end
  cameralink_pattern_gen u_pattern (
    .x      (px),
    .y      (py),
    .fcnt   (frame_cnt[11:0]),
    .pattern(pat),
    .bar    (pbar),
    .rgb    (rgb)
  );
  always_ff @(posedge I_Pixel_clk or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state      <= ST_IDLE;
      pat        <= PAT_HRAMP;
      hcnt       <= '0;
      ycnt       <= '0;
      vcnt       <= '0;
      bar        <= '0;
      bar_cnt    <= '0;
      pix        <= '0;
      fval       <= 1'b0;
      lval       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      stop       <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state != ST_IDLE && I_Stop) stop <= 1'b1;
      case (state)
        ST_IDLE:
          if (I_Start) begin
            state <= ST_FV_PRE;
            pat   <= pattern_t'(I_Pattern);
            fval  <= 1'b1;
            busy  <= 1'b1;
            hcnt  <= '0;
          end
        ST_FV_PRE:
          if (hcnt == GAP_LAST) begin
            state   <= ST_LINE;
            hcnt    <= '0;
            ycnt    <= '0;
            lval    <= 1'b1;
            pix     <= rgb;
            bar     <= pbar;
            bar_cnt <= pbar_cnt;
          end else hcnt <= hcnt + 1'b1;
        ST_LINE:
          if (hcnt == H_LAST) begin
            state <= ycnt == Y_LAST ? ST_FV_POST : ST_HBLANK;
            hcnt  <= '0;
            lval  <= 1'b0;
            pix   <= '0;
          end else begin
            hcnt    <= hcnt + 1'b1;
            pix     <= rgb;
            bar     <= pbar;
            bar_cnt <= pbar_cnt;
          end
        ST_HBLANK:
          if (hcnt == HB_LAST) begin
            state   <= ST_LINE;
            hcnt    <= '0;
            ycnt    <= ycnt + 1'b1;
            lval    <= 1'b1;
            pix     <= rgb;
            bar     <= pbar;
            bar_cnt <= pbar_cnt;
          end else hcnt <= hcnt + 1'b1;
        ST_FV_POST:
          if (hcnt == GAP_LAST) begin
            state <= ST_VBLANK;
            fval  <= 1'b0;
            vcnt  <= '0;
            // a one-cycle VBLANK is its own last cycle
            if (VB_LAST == '0) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
            end
          end else hcnt <= hcnt + 1'b1;
        ST_VBLANK:
          if (vcnt == VB_LAST) begin
            if (stop || I_Stop || !I_Continuous) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              stop  <= 1'b0;
            end else begin
              state <= ST_FV_PRE;
              pat   <= pattern_t'(I_Pattern);
              fval  <= 1'b1;
              hcnt  <= '0;
            end
          end else begin
            vcnt <= vcnt + 1'b1;
            // flag is registered, so raise it on entry to the last VBLANK cycle
            if (vcnt + 1'b1 == VB_LAST) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
            end
          end
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign O_Pixel_R    = pix[35:24];
  assign O_Pixel_G    = pix[23:12];
  assign O_Pixel_B    = pix[11:0];
  assign O_Pixel_Fval = fval;
  assign O_Pixel_Lval = lval;
  assign O_Pixel_Dval = lval;
  assign O_Busy       = busy;
  assign O_Frame_Done = frame_done;
  assign O_Frame_Cnt  = frame_cnt;
endmodule

// File: tb/tb_cameralink_timing_gen.sv
// tb_cameralink_timing_gen: directed self-checking bench for cameralink_timing_gen (16x4 active, 4 hblank, 2 vblank lines, gap 2)
module tb_cameralink_timing_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cont = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [11:0] r, g, b;
  logic        fval, lval, dval, busy, done;
  logic [15:0] fcnt;
  int          checks = 0;
  int          passes = 0;
  logic [35:0] line0 [16];
  logic [35:0] bars [8] = '{36'hfff_fff_fff, 36'hfff_fff_000, 36'h000_fff_fff, 36'h000_fff_000,
                            36'hfff_000_fff, 36'hfff_000_000, 36'h000_000_fff, 36'h000_000_000};
  always #5 clk = ~clk;
  cameralink_timing_gen #(
    .H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(4), .V_BLANK(2), .FV_GAP(2), .CNT_W(16)
  ) dut (
    .I_Pixel_clk (clk),
    .I_Rst_n     (rst_n),
    .I_Start     (start),
    .I_Stop      (stop),
    .I_Continuous(cont),
    .I_Pattern   (pattern),
    .O_Pixel_R   (r),
    .O_Pixel_G   (g),
    .O_Pixel_B   (b),
    .O_Pixel_Fval(fval),
    .O_Pixel_Lval(lval),
    .O_Pixel_Dval(dval),
    .O_Busy      (busy),
    .O_Frame_Done(done),
    .O_Frame_Cnt (fcnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  // Walks one 120-cycle frame period; caller drives the start pulse (or the
  // previous frame's boundary) so that the next negedge is the first Fval cycle.
  task automatic frame(input string tag, input int mode, input logic [11:0] flat,
                       input int stop_at, input int pat_at, input logic [1:0] new_pat);
    int fv = 0, lv = 0, bad = 0, first_fv = -1, first_lv = -1, fall_k = -1, done_k = -1;
    for (int k = 1; k <= 120; k++) begin
      logic exp_fv, exp_lv;
      logic [11:0] x12, y12;
      logic [35:0] exp_rgb;
      int x, y;
      @(negedge clk);
      exp_fv = k <= 80;
      x = (k - 3) % 20;
      y = (k - 3) / 20;
      exp_lv = k >= 3 && k <= 78 && x < 16;
      x12 = 12'(x);
      y12 = 12'(y);
      exp_rgb = !exp_lv ? 36'd0 : mode == 0 ? {3{x12}} : mode == 1 ? {3{y12}} :
                mode == 2 ? bars[x / 2] : {3{flat}};
      if (fval !== exp_fv || lval !== exp_lv || dval !== lval || {r, g, b} !== exp_rgb ||
          busy !== 1'b1 || done !== (k == 120)) bad++;
      if (fval) fv++;
      if (lval) lv++;
      if (fval && first_fv < 0) first_fv = k;
      if (lval && first_lv < 0) first_lv = k;
      if (!fval && fv > 0 && fall_k < 0) fall_k = k;
      if (done && done_k < 0) done_k = k;
      if (exp_lv && y == 0) line0[x] = {r, g, b};
      start = 1'b0;
      stop = k == stop_at;
      if (k == pat_at) pattern = new_pat;
    end
    chk({tag, " fval_len"}, 64'(fv), 64'd80);
    chk({tag, " lval_cycles"}, 64'(lv), 64'd64);
    chk({tag, " first_fval"}, 64'(first_fv), 64'd1);
    chk({tag, " first_lval"}, 64'(first_lv), 64'd3);
    chk({tag, " done_after_fall"}, 64'(done_k - fall_k + 1), 64'd40);
    chk({tag, " cycle_errors"}, 64'(bad), 64'd0);
  endtask
  task automatic kick(input logic [1:0] p, input logic c);
    @(negedge clk);
    pattern = p;
    cont = c;
    start = 1'b1;
  endtask
  initial begin
    int fv_seen;
    repeat (2) @(negedge clk);
    chk("reset fval", 64'(fval), 64'd0);
    chk("reset rgb", 64'({r, g, b}), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle busy", 64'(busy), 64'd0);
    chk("idle fcnt", 64'(fcnt), 64'd0);
    kick(2'd0, 1'b0);
    frame("p0", 0, 12'd0, 0, 0, 2'd0);
    @(negedge clk);
    chk("p0 end busy", 64'(busy), 64'd0);
    chk("p0 end fcnt", 64'(fcnt), 64'd1);
    kick(2'd2, 1'b0);
    frame("p2", 2, 12'd0, 0, 0, 2'd0);
    chk("bar px0", 64'(line0[0]), 64'h fff_fff_fff);
    chk("bar px2", 64'(line0[2]), 64'h fff_fff_000);
    chk("bar px14", 64'(line0[14]), 64'd0);
    @(negedge clk);
    chk("p2 end fcnt", 64'(fcnt), 64'd2);
    kick(2'd0, 1'b1);
    frame("cont f1", 0, 12'd0, 0, 30, 2'd1);
    frame("cont f2", 1, 12'd0, 10, 0, 2'd0);
    fv_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (fval || busy) fv_seen++;
    end
    chk("stop no third frame", 64'(fv_seen), 64'd0);
    chk("stop fcnt", 64'(fcnt), 64'd4);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    kick(2'd3, 1'b1);
    frame("flat f1", 3, 12'd4, 0, 0, 2'd0);
    frame("flat f2", 3, 12'd5, 50, 0, 2'd0);
    @(negedge clk);
    chk("latch clear busy", 64'(busy), 64'd0);
    chk("latch clear fcnt", 64'(fcnt), 64'd6);
    kick(2'd0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("hblank lval", 64'(lval), 64'd0);
    chk("hblank fval", 64'(fval), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst fval", 64'(fval), 64'd0);
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst fcnt", 64'(fcnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(2'd0, 1'b0);
    frame("post rst", 0, 12'd0, 0, 0, 2'd0);
    @(negedge clk);
    chk("post rst fcnt", 64'(fcnt), 64'd1);
    force dut.frame_cnt = 16'hffff;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    chk("forced fcnt", 64'(fcnt), 64'hffff);
    kick(2'd3, 1'b0);
    frame("wrap f1", 3, 12'hfff, 0, 0, 2'd0);
    @(negedge clk);
    chk("wrap fcnt", 64'(fcnt), 64'd0);
    kick(2'd3, 1'b0);
    frame("wrap f2", 3, 12'h000, 0, 0, 2'd0);
    @(negedge clk);
    chk("wrap f2 fcnt", 64'(fcnt), 64'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
